// File: rtl/inst_sram_axi_rd_bridge_if.sv
// Bus bundles for the instruction fetch bridge: the SRAM-like fetch port
// and the AXI4 read-address/read-data channels toward the crossbar.

interface inst_sram_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_err;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata,
    input  inst_err
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata,
    output inst_err
  );
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid,
    output araddr,
    output arlen,
    output arsize,
    output arburst,
    output arlock,
    output arcache,
    output arprot,
    output arvalid,
    input  arready,
    input  rid,
    input  rdata,
    input  rresp,
    input  rlast,
    input  rvalid,
    output rready
  );

  modport slave (
    input  arid,
    input  araddr,
    input  arlen,
    input  arsize,
    input  arburst,
    input  arlock,
    input  arcache,
    input  arprot,
    input  arvalid,
    output arready,
    output rid,
    output rdata,
    output rresp,
    output rlast,
    output rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-side SRAM-like to AXI4 single-beat read bridge; one fetch in
// flight at a time, walking IDLE -> AR -> R -> DONE.

module inst_sram_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        r_fire;
  logic        unused_r_fields;

  // State register
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sram.inst_req) state_d = AR;
      AR:   if (axi.arready)   state_d = R;
      R:    if (axi.rvalid)    state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore-style handshake outputs; addr_ok is the only one that follows an input
  always_comb begin
    sram.inst_addr_ok = 1'b0;
    sram.inst_data_ok = 1'b0;
    axi.arvalid       = 1'b0;
    axi.rready        = 1'b0;
    case (state_q)
      IDLE: sram.inst_addr_ok = sram.inst_req & cpu_rst_n;
      AR:   axi.arvalid       = 1'b1;
      R:    axi.rready        = 1'b1;
      DONE: sram.inst_data_ok = 1'b1;
      default: ;
    endcase
  end

  assign accept = sram.inst_addr_ok;
  assign r_fire = (state_q == R) && axi.rvalid;

  // Address and returned word are captured only at their handshakes
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      addr_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= sram.inst_addr;
      end
      if (r_fire) begin
        rdata_q <= axi.rdata;
        err_q   <= (axi.rresp != 2'b00);
      end
    end
  end

  assign sram.inst_rdata = rdata_q;
  assign sram.inst_err   = err_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  // Single-beat reads from a single ID make rid and rlast redundant
  assign unused_r_fields = ^{axi.rid, axi.rlast};

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Randomized directed bench for inst_sram_axi_rd_bridge with a reactive AXI
// slave and a latency/handshake reference model derived from the fetch protocol.

module tb_inst_sram_axi_rd_bridge;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  int          checks;
  int          errors;
  logic [31:0] prev_word;

  inst_sram_if sram ();
  axi_rd_if    axi ();

  inst_sram_axi_rd_bridge #(.AXI_ID(4'd0)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst_n  (cpu_rst_n),
    .sram       (sram),
    .axi        (axi)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One fetch: the initiator raises inst_req at cycle 0, the slave stalls AR
  // by ar_stall cycles and R by r_stall cycles after the AR handshake.
  task automatic apply_stimulus(input logic [31:0] addr, input int ar_stall,
                                input int r_stall, input logic [31:0] data,
                                input logic [1:0] resp, input bit hold_req,
                                input logic [31:0] next_addr);
    logic [31:0] exp_araddr;
    int   exp_dok;
    int   dok_cyc;
    int   ar_wait;
    int   r_gap;
    int   ar_hs;
    int   ar_cycles;
    int   araddr_bad;
    int   extra_ok;
    int   both;
    int   hold_bad;
    int   rready_bad;
    bit   ok_first;
    bit   took_ok;
    bit   ar_done;
    bit   r_done;
    bit   ar_fire;
    bit   r_fire;
    bit   saw_ok;
    bit   saw_arvalid;
    logic [31:0] obs_data;
    logic        obs_err;

    exp_araddr = addr & 32'hffff_fffc;
    exp_dok    = 3 + ar_stall + r_stall;
    dok_cyc = -1; ar_wait = 0; r_gap = 0; ar_hs = 0; ar_cycles = 0;
    araddr_bad = 0; extra_ok = 0; both = 0; hold_bad = 0; rready_bad = 0;
    ok_first = 0; took_ok = 0; ar_done = 0; r_done = 0;
    obs_data = 32'hx; obs_err = 1'bx;

    sram.inst_req  = 1'b1;
    sram.inst_addr = addr;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (took_ok) begin
        sram.inst_req  = hold_req;
        sram.inst_addr = next_addr;
      end
      axi.arready = axi.arvalid && (ar_wait >= ar_stall);
      axi.rvalid  = ar_done && !r_done && (r_gap >= r_stall);
      axi.rdata   = axi.rvalid ? data : $urandom;
      axi.rresp   = axi.rvalid ? resp : 2'($urandom_range(0, 3));
      axi.rid     = 4'($urandom_range(0, 15));
      axi.rlast   = axi.rvalid;

      @(negedge cpu_clk_50M);
      ar_fire     = axi.arvalid && axi.arready;
      r_fire      = axi.rready && axi.rvalid;
      saw_ok      = sram.inst_addr_ok;
      saw_arvalid = axi.arvalid;
      if (saw_ok) begin
        if (cyc == 0) ok_first = 1;
        else extra_ok++;
      end
      if (sram.inst_addr_ok && sram.inst_data_ok) both++;
      if (saw_arvalid) begin
        ar_cycles++;
        if (axi.araddr !== exp_araddr) araddr_bad++;
      end
      if (ar_fire) ar_hs++;
      if (axi.rready !== (ar_done && !r_done)) rready_bad++;
      if (sram.inst_data_ok) begin
        dok_cyc  = cyc;
        obs_data = sram.inst_rdata;
        obs_err  = sram.inst_err;
      end else if (sram.inst_rdata !== prev_word) begin
        hold_bad++;
      end

      @(posedge cpu_clk_50M);
      #1;
      if (saw_ok) took_ok = 1;
      if (ar_fire) begin
        ar_done = 1;
        r_gap   = 0;
      end else if (ar_done) begin
        r_gap++;
      end
      if (saw_arvalid && !ar_fire) ar_wait++;
      if (r_fire) r_done = 1;
      if (dok_cyc >= 0) break;
    end
    if (!took_ok) begin
      sram.inst_req = 1'b0;
    end
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;

    check_output("addr_ok_cycle0", 32'(ok_first), 32'd1);
    check_output("addr_ok_extra", extra_ok, 0);
    check_output("addr_ok_data_ok_overlap", both, 0);
    check_output("ar_handshakes", ar_hs, 1);
    check_output("arvalid_cycles", ar_cycles, ar_stall + 1);
    check_output("araddr_value", araddr_bad, 0);
    check_output("rready_window", rready_bad, 0);
    check_output("data_ok_cycle", dok_cyc, exp_dok);
    check_output("inst_rdata", obs_data, data);
    check_output("inst_err", 32'(obs_err), 32'(resp != 2'b00));
    check_output("rdata_hold", hold_bad, 0);
    prev_word = data;
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    bit          hold;

    checks         = 0;
    errors         = 0;
    prev_word      = 32'h0;
    cpu_rst_n      = 1'b0;
    sram.inst_req  = 1'b0;
    sram.inst_addr = 32'h0;
    axi.arready    = 1'b0;
    axi.rvalid     = 1'b0;
    axi.rdata      = 32'h0;
    axi.rresp      = 2'b00;
    axi.rid        = 4'h0;
    axi.rlast      = 1'b0;

    repeat (2) @(posedge cpu_clk_50M);
    #1;
    check_output("reset_arvalid", 32'(axi.arvalid), 32'd0);
    check_output("reset_rready", 32'(axi.rready), 32'd0);
    check_output("reset_addr_ok", 32'(sram.inst_addr_ok), 32'd0);
    check_output("reset_data_ok", 32'(sram.inst_data_ok), 32'd0);
    check_output("reset_rdata", sram.inst_rdata, 32'h0);
    check_output("reset_err", 32'(sram.inst_err), 32'd0);
    check_output("reset_araddr", axi.araddr, 32'h0);
    check_output("const_arlen", 32'(axi.arlen), 32'd0);
    check_output("const_arsize", 32'(axi.arsize), 32'd2);
    check_output("const_arburst", 32'(axi.arburst), 32'd1);
    check_output("const_arid", 32'(axi.arid), 32'd0);
    check_output("const_arlock_cache_prot",
                 32'({axi.arlock, axi.arcache, axi.arprot}), 32'd0);
    cpu_rst_n = 1'b1;

    $display("[TB] basic fetch");
    apply_stimulus(32'h1fc0_0000, 0, 0, 32'h3c1d_0000, 2'b00, 0, 32'h0);
    $display("[TB] AR backpressure");
    apply_stimulus(32'h1fc0_0100, 5, 0, 32'h2408_0001, 2'b00, 0, 32'h0);
    $display("[TB] R backpressure with error");
    apply_stimulus(32'h1fc0_0200, 0, 4, 32'hdead_beef, 2'b10, 0, 32'h0);
    $display("[TB] back-to-back");
    apply_stimulus(32'h1fc0_0000, 0, 0, 32'h1111_2222, 2'b00, 1, 32'h1fc0_0004);
    apply_stimulus(32'h1fc0_0004, 1, 2, 32'h3333_4444, 2'b00, 0, 32'h0);
    $display("[TB] misaligned");
    apply_stimulus(32'h1fc0_0006, 0, 0, 32'h5555_6666, 2'b00, 0, 32'h0);

    $display("[TB] reset mid-transaction");
    sram.inst_req  = 1'b1;
    sram.inst_addr = 32'h1fc0_0010;
    axi.arready    = 1'b1;
    axi.rvalid     = 1'b0;
    @(posedge cpu_clk_50M);
    #1;
    sram.inst_req = 1'b0;
    @(posedge cpu_clk_50M);
    #1;
    check_output("mid_reset_in_r", 32'(axi.rready), 32'd1);
    cpu_rst_n   = 1'b0;
    axi.arready = 1'b0;
    @(posedge cpu_clk_50M);
    #1;
    check_output("mid_reset_rready", 32'(axi.rready), 32'd0);
    check_output("mid_reset_arvalid", 32'(axi.arvalid), 32'd0);
    check_output("mid_reset_data_ok", 32'(sram.inst_data_ok), 32'd0);
    check_output("mid_reset_rdata", sram.inst_rdata, 32'h0);
    cpu_rst_n = 1'b1;
    prev_word = 32'h0;
    apply_stimulus(32'h1fc0_0020, 2, 1, 32'h7777_8888, 2'b01, 0, 32'h0);

    $display("[TB] randomized fetches");
    cur = $urandom;
    for (int i = 0; i < 24; i++) begin
      nxt  = $urandom;
      hold = 1'($urandom_range(0, 1));
      apply_stimulus(cur, $urandom_range(0, 6), $urandom_range(0, 6),
                     $urandom | 32'h1, 2'($urandom_range(0, 3)), hold, nxt);
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
